// File: rtl/coh_avg_pkg.sv
// Shared types and helpers for the coherent-average run sequencer.
// Holds the one-hot state encoding, default widths and the saturating increment.
package coh_avg_pkg;

    localparam int unsigned M_DEF      = 32;
    localparam int unsigned N_DEF      = 3;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 1048576;
    localparam int unsigned IDX_W      = $clog2(M_DEF);
    localparam int unsigned WCNT_W     = $clog2(M_DEF) + 1;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_CLEAR = 6'b000010,
        ST_ARM   = 6'b000100,
        ST_ACQ   = 6'b001000,
        ST_READ  = 6'b010000,
        ST_DONE  = 6'b100000
    } state_t;

    // Increment v, holding at the all-ones value of a w-bit counter (1 <= w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = 32'hFFFF_FFFF >> (32 - w);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/coh_avg_wdog.sv
// Cycle watchdog: counts while run is high, restarts on clear.
// expired is high during the LIMIT-th consecutive run cycle.
module coh_avg_wdog #(
    parameter int unsigned LIMIT = 1048576
) (
    input  logic clk_rapido,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT);

    logic [CW-1:0] cnt;

    // cnt holds the number of run cycles already completed
    always_ff @(posedge clk_rapido) begin
        if (reset || clear || !run) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            expired <= (cnt == CW'(LIMIT - 2));
        end
    end

endmodule

// File: rtl/coherent_average_ctrl.sv
// Run sequencer for the coherent averager: clear, arm, acquire N*M samples, read M words.
// Optional watchdog on ARM/READ built only when COH_AVG_TIMEOUT_EN is defined.
module coherent_average_ctrl
    import coh_avg_pkg::*;
#(
    parameter int unsigned M           = M_DEF,
    parameter int unsigned N           = N_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                  clk_rapido,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  trigger,
    input  logic                  x_valid,
    input  logic                  avg_rd_valid,
    output logic                  avg_enable,
    output logic                  avg_x_valid,
    output logic                  avg_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  sync_err,
    output logic                  timeout,
    output logic [CNT_W-1:0]      period_cnt,
    output logic [$clog2(M):0]    word_cnt
);

    localparam int unsigned IW = $clog2(M);
    localparam int unsigned WW = IW + 1;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    if ((M < 4) || ((M & (M - 1)) != 0)) begin : g_bad_m
        $error("M must be a power of two and at least 4");
    end
    if (N < 1) begin : g_bad_n
        $error("N must be at least 1");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [PW-1:0]   per, per_nxt;
    logic [CNT_W-1:0] pcnt_nxt;
    logic [WW-1:0]   wcnt_nxt;
    logic            serr_nxt;
    logic            busy_nxt, done_nxt, clr_nxt;
    logic            start_run_c, stop_c;

`ifdef COH_AVG_TIMEOUT_EN
    logic wdog_exp;
    logic state_chg_c;
    logic wdog_run_c;

    assign state_chg_c = (state_nxt != state);
    assign wdog_run_c  = (state == ST_ARM) || (state == ST_READ);

    coh_avg_wdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk_rapido (clk_rapido),
        .reset      (reset),
        .clear      (state_chg_c),
        .run        (wdog_run_c),
        .expired    (wdog_exp)
    );

    // Sticky timeout flag, cleared only when a new run starts
    always_ff @(posedge clk_rapido) begin
        if (reset) begin
            timeout <= 1'b0;
        end else if (start_run_c) begin
            timeout <= 1'b0;
        end else if (wdog_exp && !abort) begin
            timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Sample gating is combinational so the averager's data path needs no delay
    assign avg_x_valid = x_valid && ((state == ST_ACQ) || ((state == ST_ARM) && trigger));

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        per_nxt     = per;
        pcnt_nxt    = period_cnt;
        wcnt_nxt    = word_cnt;
        serr_nxt    = sync_err;
        start_run_c = 1'b0;
        stop_c      = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    start_run_c = 1'b1;
                    state_nxt   = ST_CLEAR;
                    idx_nxt     = '0;
                    per_nxt     = '0;
                    pcnt_nxt    = '0;
                    wcnt_nxt    = '0;
                    serr_nxt    = 1'b0;
                end
            end
            // idx doubles as the clear-cycle counter
            ST_CLEAR: begin
                if (idx == IW'(M - 1)) begin
                    state_nxt = ST_ARM;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            ST_ARM: begin
                if (trigger && x_valid) begin
                    state_nxt = ST_ACQ;
                    idx_nxt   = IW'(1);
                end
            end
            ST_ACQ: begin
                if (trigger && (idx != '0)) begin
                    serr_nxt = 1'b1;
                end
                if (x_valid) begin
                    idx_nxt = idx + 1'b1;
                    if (idx == IW'(M - 1)) begin
                        pcnt_nxt = CNT_W'(sat_inc(32'(period_cnt), CNT_W));
                        if (per == PW'(N - 1)) begin
                            state_nxt = ST_READ;
                        end else begin
                            per_nxt = per + 1'b1;
                        end
                    end
                end
            end
            ST_READ: begin
                if (avg_rd_valid) begin
                    wcnt_nxt = word_cnt + 1'b1;
                    if (word_cnt == WW'(M - 1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        stop_c = abort && (state != ST_IDLE);
`ifdef COH_AVG_TIMEOUT_EN
        if (wdog_exp) begin
            stop_c = 1'b1;
        end
`endif
        // Early stop keeps counters and flags frozen for the host
        if (stop_c) begin
            state_nxt = ST_IDLE;
            idx_nxt   = idx;
            per_nxt   = per;
            pcnt_nxt  = period_cnt;
            wcnt_nxt  = word_cnt;
            serr_nxt  = sync_err;
        end

        busy_nxt = (state_nxt == ST_CLEAR) || (state_nxt == ST_ARM) ||
                   (state_nxt == ST_ACQ)   || (state_nxt == ST_READ);
        done_nxt = (state_nxt == ST_DONE);
        clr_nxt  = (state_nxt == ST_CLEAR) || stop_c;
    end

    always_ff @(posedge clk_rapido) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            per        <= '0;
            period_cnt <= '0;
            word_cnt   <= '0;
            sync_err   <= 1'b0;
            busy       <= 1'b0;
            avg_enable <= 1'b0;
            done       <= 1'b0;
            avg_clear  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            per        <= per_nxt;
            period_cnt <= pcnt_nxt;
            word_cnt   <= wcnt_nxt;
            sync_err   <= serr_nxt;
            busy       <= busy_nxt;
            avg_enable <= busy_nxt;
            done       <= done_nxt;
            avg_clear  <= clr_nxt;
        end
    end

endmodule

// File: tb/tb_coherent_average_ctrl.sv
// Scoreboard bench for coherent_average_ctrl with M=4, N=3, TIMEOUT_CYC=100.
// The timeout scenario runs only when COH_AVG_TIMEOUT_EN is defined.
module tb_coherent_average_ctrl;

    localparam int unsigned M     = 4;
    localparam int unsigned N     = 3;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TOC   = 100;

    logic clk_rapido;
    logic reset;
    logic start, abort, trigger, x_valid, avg_rd_valid;
    logic avg_enable, avg_x_valid, avg_clear, busy, done, sync_err, timeout;
    logic [CNT_W-1:0]       period_cnt;
    logic [$clog2(M):0]     word_cnt;

    typedef struct {
        int pcnt;
        int wcnt;
        int serr;
    } exp_t;

    exp_t q_admit[$];
    exp_t q_done[$];
    int   q_clr[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    coherent_average_ctrl #(
        .M           (M),
        .N           (N),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TOC)
    ) dut (
        .clk_rapido   (clk_rapido),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .trigger      (trigger),
        .x_valid      (x_valid),
        .avg_rd_valid (avg_rd_valid),
        .avg_enable   (avg_enable),
        .avg_x_valid  (avg_x_valid),
        .avg_clear    (avg_clear),
        .busy         (busy),
        .done         (done),
        .sync_err     (sync_err),
        .timeout      (timeout),
        .period_cnt   (period_cnt),
        .word_cnt     (word_cnt)
    );

    initial clk_rapido = 1'b0;
    always #5 clk_rapido = ~clk_rapido;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_admit(input int p, input int s);
        exp_t e;
        e.pcnt = p; e.wcnt = 0; e.serr = s;
        q_admit.push_back(e);
    endfunction

    function automatic void push_done(input int p, input int w, input int s);
        exp_t e;
        e.pcnt = p; e.wcnt = w; e.serr = s;
        q_done.push_back(e);
    endfunction

    // Hold one input vector for exactly one clock cycle
    task automatic drive(input logic s, input logic a, input logic t, input logic x, input logic r);
        start = s; abort = a; trigger = t; x_valid = x; avg_rd_valid = r;
        @(posedge clk_rapido); #1;
        start = 1'b0; abort = 1'b0; trigger = 1'b0; x_valid = 1'b0; avg_rd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Start a run and walk through the M clear cycles
    task automatic start_run();
        q_clr.push_back(M);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(M);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_avg_enable"}, 32'(avg_enable), 32'd0);
        chk({tag, "_avg_x_valid"}, 32'(avg_x_valid), 32'd0);
        chk({tag, "_avg_clear"}, 32'(avg_clear), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_sync_err"}, 32'(sync_err), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_period_cnt"}, 32'(period_cnt), 32'd0);
        chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a sample, clear pulse or done
    initial begin
        int   clr_len;
        logic prev_done;
        exp_t e;
        clr_len   = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk_rapido);
            if (mon_en) begin
                if (avg_x_valid === 1'b1) begin
                    if (q_admit.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_admit: avg_x_valid=1, expected no admission (t=%0t)", $time);
                    end else begin
                        e = q_admit.pop_front();
                        chk("admit_period_cnt", 32'(period_cnt), 32'(e.pcnt));
                        chk("admit_sync_err", 32'(sync_err), 32'(e.serr));
                    end
                end
                if (avg_clear === 1'b1) begin
                    clr_len++;
                end else if (clr_len > 0) begin
                    if (q_clr.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_clear: pulse of %0d cycles, expected none (t=%0t)", clr_len, $time);
                    end else begin
                        chk("clear_len", 32'(clr_len), 32'(q_clr.pop_front()));
                    end
                    clr_len = 0;
                end
                if ((done === 1'b1) && (prev_done !== 1'b1)) begin
                    if (q_done.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_done: done rose, expected it low (t=%0t)", $time);
                    end else begin
                        e = q_done.pop_front();
                        chk("done_period_cnt", 32'(period_cnt), 32'(e.pcnt));
                        chk("done_word_cnt", 32'(word_cnt), 32'(e.wcnt));
                        chk("done_sync_err", 32'(sync_err), 32'(e.serr));
                        chk("done_busy", 32'(busy), 32'd0);
                    end
                end
                prev_done = done;
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0; abort = 1'b0; trigger = 1'b0; x_valid = 1'b0; avg_rd_valid = 1'b0;
        repeat (2) @(posedge clk_rapido);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        chk_all_zero("reset");

        // 1: samples every cycle; inputs during CLEAR and READ must be ignored
        q_clr.push_back(M);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_busy_clear", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            push_admit(k / 4, 0);
            drive(1'b0, 1'b0, 1'(k % 4 == 0), 1'b1, 1'b0);
        end
        chk("t1_period_cnt", 32'(period_cnt), 32'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        push_done(3, 4, 0);
        for (int w = 0; w < 4; w++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_word_cnt_held", 32'(word_cnt), 32'd4);

        // 2: sparse samples; lone trigger or lone x_valid in ARM is ignored
        start_run();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_still_armed_cnt", 32'(period_cnt), 32'd0);
        push_admit(0, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 12; k++) begin
            idle(2);
            push_admit(k / 4, 0);
            drive(1'b0, 1'b0, 1'(k % 4 == 0), 1'b1, 1'b0);
        end
        push_done(3, 4, 0);
        for (int w = 0; w < 4; w++) begin
            idle(1);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("t2_sync_err", 32'(sync_err), 32'd0);

        // 3: stray trigger at index 2 of period 1
        start_run();
        for (int k = 0; k < 12; k++) begin
            push_admit(k / 4, (k > 6) ? 1 : 0);
            drive(1'b0, 1'b0, 1'((k % 4 == 0) || (k == 6)), 1'b1, 1'b0);
        end
        push_done(3, 4, 1);
        for (int w = 0; w < 4; w++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_sync_err", 32'(sync_err), 32'd1);

        // 4: abort together with start at sample index 5
        start_run();
        for (int k = 0; k < 5; k++) begin
            push_admit(k / 4, 0);
            drive(1'b0, 1'b0, 1'(k % 4 == 0), 1'b1, 1'b0);
        end
        push_admit(1, 0);
        q_clr.push_back(1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_avg_enable", 32'(avg_enable), 32'd0);
        chk("t4_avg_clear", 32'(avg_clear), 32'd1);
        chk("t4_period_cnt", 32'(period_cnt), 32'd1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_period_cnt_held", 32'(period_cnt), 32'd1);
        chk("t4_done", 32'(done), 32'd0);

`ifdef COH_AVG_TIMEOUT_EN
        // 5: no trigger in ARM, watchdog fires after 100 ARM cycles
        start_run();
        idle(TOC - 1);
        chk("t5_timeout_early", 32'(timeout), 32'd0);
        chk("t5_busy_early", 32'(busy), 32'd1);
        q_clr.push_back(1);
        idle(1);
        chk("t5_timeout", 32'(timeout), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        q_clr.push_back(M);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_timeout_cleared", 32'(timeout), 32'd0);
        idle(M);
        q_clr.push_back(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_abort_idle", 32'(busy), 32'd0);
`endif

        // 6: reset in READ after two words
        start_run();
        for (int k = 0; k < 12; k++) begin
            push_admit(k / 4, 0);
            drive(1'b0, 1'b0, 1'(k % 4 == 0), 1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_word_cnt_pre", 32'(word_cnt), 32'd2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk_all_zero("t6");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_word_cnt_post", 32'(word_cnt), 32'd0);

        idle(3);
        chk("q_admit_empty", 32'(q_admit.size()), 32'd0);
        chk("q_clr_empty", 32'(q_clr.size()), 32'd0);
        chk("q_done_empty", 32'(q_done.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
